// File: rtl/etc_block_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : etc_block_pixel_sequencer
// Brief    : Steps the ETC2 decoder through 16 pixels of one block and drains
//            the tile as four 128-bit row beats. Option: ETC_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module etc_block_pixel_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int PIX_W   = 8
) (
    input  logic                 sclk,
    input  logic                 rsrt,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_block,
    input  logic [0:2]           in_mode,
    input  logic                 in_alpha,
    output logic                 dec_rtr,
    output logic [63:0]          dec_block,
    output logic [0:2]           dec_mode,
    output logic                 dec_aplha,
    output logic [3:0]           dec_pixIdx,
    input  logic                 dec_color_rts,
    input  logic [PIX_W-1:0]     dec_r,
    input  logic [PIX_W-1:0]     dec_g,
    input  logic [PIX_W-1:0]     dec_b,
    input  logic [PIX_W-1:0]     dec_a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*PIX_W-1:0]  out_data,
    output logic [1:0]           out_row,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [4*PIX_W-1:0] C_MAGENTA =
        {{PIX_W{1'b1}}, {PIX_W{1'b0}}, {PIX_W{1'b1}}, {PIX_W{1'b1}}};

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         row_q, row_d;
    logic [63:0]        block_q, block_d;
    logic [0:2]         mode_q, mode_d;
    logic               alpha_q, alpha_d;
    logic [4*PIX_W-1:0] tile_q [16];

    logic               w_accept;
    logic               w_tmo;
    logic               w_pix_done;
    logic [4*PIX_W-1:0] w_wdata;
    logic [16*PIX_W-1:0] w_row_data;

    assign w_accept   = (state_q == ST_IDLE) && in_valid;
    assign w_pix_done = (state_q == ST_WAIT) && (dec_color_rts || w_tmo);
    assign w_wdata    = w_tmo ? C_MAGENTA : {dec_r, dec_g, dec_b, dec_a};

    // State register
    always_ff @(posedge sclk) begin
        if (rsrt) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (w_pix_done) state_d = (cnt_q == 4'd15) ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: if (out_ready && (row_q == 2'd3)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        dec_rtr   = (state_q == ST_ISSUE);
        out_valid = (state_q == ST_DRAIN);
        out_last  = (state_q == ST_DRAIN) && (row_q == 2'd3);
        busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        cnt_d   = cnt_q;
        row_d   = row_q;
        block_d = block_q;
        mode_d  = mode_q;
        alpha_d = alpha_q;
        if (w_accept) begin
            block_d = in_block;
            mode_d  = in_mode;
            alpha_d = in_alpha;
            cnt_d   = 4'd0;
        end
        if (w_pix_done) begin
            if (cnt_q == 4'd15) row_d = 2'd0;
            else                cnt_d = cnt_q + 4'd1;
        end
        if ((state_q == ST_DRAIN) && out_ready) row_d = row_q + 2'd1;
    end

    always_ff @(posedge sclk) begin
        if (rsrt) begin
            cnt_q   <= 4'd0;
            row_q   <= 2'd0;
            block_q <= 64'd0;
            mode_q  <= 3'd0;
            alpha_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            block_q <= block_d;
            mode_q  <= mode_d;
            alpha_q <= alpha_d;
        end
    end

    // Tile contents need no reset; every slot is rewritten before a drain
    always_ff @(posedge sclk) begin
        if (w_pix_done) tile_q[cnt_q] <= w_wdata;
    end

    // Column-major ETC indexing: row y, column x lives in slot x*4 + y
    for (genvar x = 0; x < 4; x++) begin : g_col
        assign w_row_data[x*4*PIX_W +: 4*PIX_W] = tile_q[{2'(x), row_q}];
    end

`ifdef ETC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q | w_tmo;
        if (state_q == ST_ISSUE)     tmo_d = '0;
        else if (state_q == ST_WAIT) tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge sclk) begin
        if (rsrt) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign w_tmo = (state_q == ST_WAIT) && !dec_color_rts && (tmo_q == TW'(TIMEOUT - 1));
    assign err   = err_q;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    assign dec_block  = block_q;
    assign dec_mode   = mode_q;
    assign dec_aplha  = alpha_q;
    assign dec_pixIdx = cnt_q;
    assign out_data   = w_row_data;
    assign out_row    = row_q;

endmodule
`default_nettype wire

// File: tb/tb_etc_block_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_etc_block_pixel_sequencer
// Brief    : Directed bench with a latency-configurable decoder model.
// Revision : 1.0
// ============================================================================
module tb_etc_block_pixel_sequencer;

    localparam int TIMEOUT = 64;

    logic         sclk = 1'b0;
    logic         rsrt = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_block = 64'd0;
    logic [0:2]   in_mode = 3'd0;
    logic         in_alpha = 1'b0;
    logic         dec_rtr;
    logic [63:0]  dec_block;
    logic [0:2]   dec_mode;
    logic         dec_aplha;
    logic [3:0]   dec_pixIdx;
    logic         dec_color_rts = 1'b0;
    logic [7:0]   dec_r = 8'd0, dec_g = 8'd0, dec_b = 8'd0, dec_a = 8'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [1:0]   out_row;
    logic         out_last;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         dec_lat    = 2;
    logic [7:0] dec_salt   = 8'd0;
    int         silent_idx = -1;
    logic       spur_en    = 1'b0;
    logic       pend       = 1'b0;
    int         pcnt       = 0;
    logic [3:0] pidx       = 4'd0;

    etc_block_pixel_sequencer #(.TIMEOUT(TIMEOUT), .PIX_W(8)) u_dut (
        .sclk(sclk), .rsrt(rsrt),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_mode(in_mode), .in_alpha(in_alpha),
        .dec_rtr(dec_rtr), .dec_block(dec_block), .dec_mode(dec_mode),
        .dec_aplha(dec_aplha), .dec_pixIdx(dec_pixIdx),
        .dec_color_rts(dec_color_rts),
        .dec_r(dec_r), .dec_g(dec_g), .dec_b(dec_b), .dec_a(dec_a),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Decoder model: answers a request L cycles after the cycle following rtr
    always @(negedge sclk) begin
        dec_color_rts = 1'b0;
        dec_r = 8'd0; dec_g = 8'd0; dec_b = 8'd0; dec_a = 8'd0;
        if (rsrt) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (pcnt == 0) begin
                    pend = 1'b0;
                    if (int'(pidx) != silent_idx) begin
                        dec_color_rts = 1'b1;
                        dec_r = 8'(pidx) + dec_salt;
                        dec_g = 8'h10 + 8'(pidx);
                        dec_b = 8'h20 + 8'(pidx);
                        dec_a = 8'hFF;
                    end
                end else begin
                    pcnt = pcnt - 1;
                end
            end else if (spur_en) begin
                dec_color_rts = 1'b1;
                dec_r = 8'hDE; dec_g = 8'hAD; dec_b = 8'hBE; dec_a = 8'hEF;
            end
            if (dec_rtr) begin
                pend = 1'b1;
                pcnt = dec_lat;
                pidx = dec_pixIdx;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        @(negedge sclk);
    endtask

    function automatic logic [31:0] exp_pix(input int idx, input logic [7:0] salt);
        logic [7:0] r;
        if (idx == silent_idx) return 32'hFF00FFFF;
        r = 8'(idx) + salt;
        return {r, 8'(8'h10 + idx), 8'(8'h20 + idx), 8'hFF};
    endfunction

    function automatic logic [127:0] exp_row(input int y, input logic [7:0] salt);
        logic [127:0] v;
        for (int x = 0; x < 4; x++) v[x*32 +: 32] = exp_pix(x*4 + y, salt);
        return v;
    endfunction

    task automatic send(input logic [63:0] blk, input logic [2:0] mode, input logic alpha, input logic hold);
        int w;
        in_block = blk; in_mode = mode; in_alpha = alpha; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 300) begin tick(); w++; end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic run_pixels();
        int last;
        int w;
        last = 0;
        for (int p = 0; p < 16; p++) begin
            w = 0;
            while (!dec_rtr && w < 200) begin tick(); w++; end
            if (!dec_rtr) begin
                chk("rtr_wait", 0, 1);
                return;
            end
            chk("pixidx", dec_pixIdx, p);
            if (p > 0) chk("rtr_gap", cyc - last, (p - 1 == silent_idx) ? TIMEOUT + 1 : 2 + dec_lat);
            last = cyc;
            tick();
            chk("rtr_one_cycle", dec_rtr, 0);
        end
    endtask

    task automatic drain(input logic [3:0] pat, input logic [7:0] salt);
        int ph;
        int w;
        logic acc;
        ph = 0;
        w = 0;
        while (!out_valid && w < 200) begin tick(); w++; end
        if (!out_valid) chk("out_valid_wait", 0, 1);
        for (int y = 0; y < 4; y++) begin
            acc = 1'b0;
            w = 0;
            while (!acc && w < 20) begin
                out_ready = pat[ph % 4];
                ph++;
                chk("beat_valid", out_valid, 1);
                chk("beat_row", out_row, y);
                chk("beat_data", out_data, exp_row(y, salt));
                chk("beat_last", out_last, (y == 3));
                chk("in_ready_drain", in_ready, 0);
                if (y == 0 && salt == 8'd0 && silent_idx < 0)
                    chk("row0_hand", out_data, 128'h0C1C2CFF_081828FF_041424FF_001020FF);
                acc = out_ready;
                tick();
                w++;
            end
        end
        out_ready = 1'b0;
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_out_valid", out_valid, 0);
    endtask

    initial begin
        int seen;
        logic [63:0] blk_a;
        logic [63:0] blk_b;
        blk_a = 64'h0123456789ABCDEF;
        blk_b = 64'hFEDCBA9876543210;

        // Reset and idle
        repeat (3) tick();
        rsrt = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dec_rtr", dec_rtr, 0);
        chk("rst_pixidx", dec_pixIdx, 0);
        chk("rst_dec_block", dec_block, 0);
        chk("rst_dec_mode", dec_mode, 0);
        chk("rst_dec_alpha", dec_aplha, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        // Basic block, L=2, always ready
        dec_lat = 2; dec_salt = 8'd0;
        send(blk_a, 3'b100, 1'b0, 1'b0);
        chk("a_block", dec_block, blk_a);
        chk("a_mode", dec_mode, 3'b100);
        chk("a_alpha", dec_aplha, 0);
        chk("a_busy", busy, 1);
        run_pixels();
        drain(4'b1111, dec_salt);

        // Backpressure 1-0-0-1 with stray rts during drain
        dec_salt = 8'h80;
        send(blk_a, 3'b100, 1'b1, 1'b0);
        chk("b_alpha", dec_aplha, 1);
        run_pixels();
        spur_en = 1'b1;
        drain(4'b1001, dec_salt);
        spur_en = 1'b0;

        // Second block held on the input while the first is processed
        dec_salt = 8'h40; dec_lat = 1;
        send(blk_a, 3'b010, 1'b0, 1'b1);
        in_block = blk_b;
        in_mode  = 3'b011;
        chk("c_in_ready_busy", in_ready, 0);
        run_pixels();
        chk("c_block_held", dec_block, blk_a);
        drain(4'b1111, dec_salt);
        tick();
        in_valid = 1'b0;
        chk("c_block_next", dec_block, blk_b);
        chk("c_mode_next", dec_mode, 3'b011);
        chk("c_busy_next", busy, 1);
        dec_salt = 8'h50;
        run_pixels();
        drain(4'b1111, dec_salt);

        // Reset while waiting on pixel 7
        dec_salt = 8'h20; dec_lat = 2;
        send(blk_b, 3'b001, 1'b1, 1'b0);
        seen = 0;
        while (!(dec_rtr && dec_pixIdx == 4'd7) && seen < 200) begin tick(); seen++; end
        chk("d_reached_px7", dec_pixIdx, 7);
        tick();
        rsrt = 1'b1;
        tick();
        chk("d_rst_busy", busy, 0);
        chk("d_rst_in_ready", in_ready, 1);
        chk("d_rst_block", dec_block, 0);
        chk("d_rst_pixidx", dec_pixIdx, 0);
        tick();
        rsrt = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("d_no_beat", seen, 0);
        dec_lat = 0; dec_salt = 8'h33;
        send(blk_a, 3'b111, 1'b0, 1'b0);
        run_pixels();
        drain(4'b1111, dec_salt);

`ifdef ETC_SEQ_TIMEOUT_EN
        // Decoder silent for pixel 5
        chk("e_err_before", err, 0);
        dec_lat = 1; dec_salt = 8'h00; silent_idx = 5;
        send(blk_b, 3'b100, 1'b0, 1'b0);
        run_pixels();
        chk("e_err_set", err, 1);
        drain(4'b1111, dec_salt);
        chk("e_err_sticky", err, 1);
        silent_idx = -1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
